// File: rtl/tcb_lite_lib_interconnect.sv
// Parametrised 1-to-IFN TCB-Lite load/store interconnect: base/mask address decode,
// fixed-latency response routing, internal error response for unmapped addresses.
module tcb_lite_lib_interconnect #(
    parameter int unsigned               IFN     = 4,
    parameter int unsigned               ADR     = 32,
    parameter int unsigned               DAT     = 32,
    parameter int unsigned               DLY     = 1,
    parameter logic [IFN-1:0][ADR-1:0]   ADR_BAS = '0,
    parameter logic [IFN-1:0][ADR-1:0]   ADR_MSK = '0,
    parameter int unsigned               CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sub_vld,
    output logic                 sub_rdy,
    input  logic                 sub_wen,
    input  logic [ADR-1:0]       sub_adr,
    input  logic [DAT/8-1:0]     sub_byt,
    input  logic [DAT-1:0]       sub_wdt,
    output logic [DAT-1:0]       sub_rdt,
    output logic                 sub_err,
    output logic                 sub_rsp,
    output logic [IFN-1:0]       man_vld,
    input  logic [IFN-1:0]       man_rdy,
    output logic                 man_wen,
    output logic [ADR-1:0]       man_adr,
    output logic [DAT/8-1:0]     man_byt,
    output logic [DAT-1:0]       man_wdt,
    input  logic [IFN*DAT-1:0]   man_rdt,
    input  logic [IFN-1:0]       man_err,
    output logic [CNT_W-1:0]     mis_cnt,
    input  logic                 mis_clr
);

    localparam int unsigned IDX_W = (IFN > 1) ? $clog2(IFN) : 1;

    if (IFN < 1 || IFN > 16 || DLY > 4 || (DAT % 8) != 0) begin : g_param_err
        $error("tcb_lite_lib_interconnect: illegal IFN, DLY or DAT");
    end

    logic             hit;
    logic [IDX_W-1:0] sel;
    logic             miss;
    logic             xfer;
    logic             rsp_vld;
    logic [IDX_W-1:0] rsp_idx;
    logic             rsp_mis;
    logic             rsp_man_err;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Scan from the top index down so the lowest hitting window wins.
    always_comb begin
        hit = 1'b0;
        sel = '0;
        for (int i = int'(IFN) - 1; i >= 0; i--) begin
            if (((sub_adr ^ ADR_BAS[i]) & ADR_MSK[i]) == '0) begin
                hit = 1'b1;
                sel = IDX_W'(i);
            end
        end
    end

    assign miss = !hit;
    assign xfer = sub_vld && sub_rdy;

    always_comb begin
        man_vld = '0;
        sub_rdy = 1'b1;
        for (int i = 0; i < int'(IFN); i++) begin
            if (hit && sel == IDX_W'(i)) begin
                man_vld[i] = sub_vld;
                sub_rdy    = man_rdy[i];
            end
        end
    end

    assign man_wen = sub_wen;
    assign man_adr = sub_adr;
    assign man_byt = sub_byt;
    assign man_wdt = sub_wdt;

    if (DLY > 0) begin : g_pipe
        logic [DLY-1:0]            vld_q, vld_d;
        logic [DLY-1:0]            mis_q, mis_d;
        logic [DLY-1:0][IDX_W-1:0] idx_q, idx_d;

        always_comb begin
            vld_d[0] = xfer;
            mis_d[0] = miss;
            idx_d[0] = sel;
            for (int s = 1; s < int'(DLY); s++) begin
                vld_d[s] = vld_q[s-1];
                mis_d[s] = mis_q[s-1];
                idx_d[s] = idx_q[s-1];
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                vld_q <= '0;
                mis_q <= '0;
                idx_q <= '0;
            end else begin
                vld_q <= vld_d;
                mis_q <= mis_d;
                idx_q <= idx_d;
            end
        end

        assign rsp_vld = vld_q[DLY-1];
        assign rsp_mis = mis_q[DLY-1];
        assign rsp_idx = idx_q[DLY-1];
    end else begin : g_bypass
        assign rsp_vld = xfer;
        assign rsp_mis = miss;
        assign rsp_idx = sel;
    end

    always_comb begin
        sub_rdt     = '0;
        rsp_man_err = 1'b0;
        for (int i = 0; i < int'(IFN); i++) begin
            if (rsp_idx == IDX_W'(i)) begin
                rsp_man_err = man_err[i];
                if (rsp_vld && !rsp_mis) begin
                    sub_rdt = man_rdt[i*DAT +: DAT];
                end
            end
        end
        sub_rsp = rsp_vld;
        sub_err = rsp_vld && (rsp_mis || rsp_man_err);
    end

    // Clear wins over a same-cycle increment; increment stops at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (mis_clr) begin
            cnt_d = '0;
        end else if (xfer && miss && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign mis_cnt = cnt_q;

endmodule

// File: tb/tb_tcb_lite_lib_interconnect.sv
// Directed bench for tcb_lite_lib_interconnect: three instances (DLY=1, DLY=2 with a
// 2-bit miss counter, DLY=0) share one stimulus stream.
module tb_tcb_lite_lib_interconnect;

    localparam logic [3:0][31:0] BAS = {32'h0030_0000, 32'h0020_0040, 32'h0020_0000, 32'h0000_0000};
    localparam logic [3:0][31:0] MSK = {32'hfff0_0000, 32'hffff_ffc0, 32'hffff_ffc0, 32'hffe0_0000};
    localparam logic [127:0]     RDT = {32'h4444_3333, 32'hCAFE_F00D, 32'h2222_1111, 32'h1111_0000};

    logic        clk = 1'b0;
    logic        rst;
    logic        sub_vld, sub_wen, mis_clr;
    logic [31:0] sub_adr, sub_wdt;
    logic [3:0]  sub_byt, man_rdy, man_err;
    logic [127:0] man_rdt;

    logic        rdy_a, rdy_b, rdy_c;
    logic [31:0] rdt_a, rdt_b, rdt_c;
    logic        err_a, err_b, err_c;
    logic        rsp_a, rsp_b, rsp_c;
    logic [3:0]  mvld_a, mvld_b, mvld_c;
    logic        mwen_a, mwen_b, mwen_c;
    logic [31:0] madr_a, madr_b, madr_c;
    logic [3:0]  mbyt_a, mbyt_b, mbyt_c;
    logic [31:0] mwdt_a, mwdt_b, mwdt_c;
    logic [7:0]  cnt_a, cnt_c;
    logic [1:0]  cnt_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tcb_lite_lib_interconnect #(.IFN(4), .ADR(32), .DAT(32), .DLY(1), .ADR_BAS(BAS), .ADR_MSK(MSK), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .sub_vld(sub_vld), .sub_rdy(rdy_a), .sub_wen(sub_wen), .sub_adr(sub_adr),
        .sub_byt(sub_byt), .sub_wdt(sub_wdt), .sub_rdt(rdt_a), .sub_err(err_a), .sub_rsp(rsp_a),
        .man_vld(mvld_a), .man_rdy(man_rdy), .man_wen(mwen_a), .man_adr(madr_a), .man_byt(mbyt_a),
        .man_wdt(mwdt_a), .man_rdt(man_rdt), .man_err(man_err), .mis_cnt(cnt_a), .mis_clr(mis_clr));

    tcb_lite_lib_interconnect #(.IFN(4), .ADR(32), .DAT(32), .DLY(2), .ADR_BAS(BAS), .ADR_MSK(MSK), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .sub_vld(sub_vld), .sub_rdy(rdy_b), .sub_wen(sub_wen), .sub_adr(sub_adr),
        .sub_byt(sub_byt), .sub_wdt(sub_wdt), .sub_rdt(rdt_b), .sub_err(err_b), .sub_rsp(rsp_b),
        .man_vld(mvld_b), .man_rdy(man_rdy), .man_wen(mwen_b), .man_adr(madr_b), .man_byt(mbyt_b),
        .man_wdt(mwdt_b), .man_rdt(man_rdt), .man_err(man_err), .mis_cnt(cnt_b), .mis_clr(mis_clr));

    tcb_lite_lib_interconnect #(.IFN(4), .ADR(32), .DAT(32), .DLY(0), .ADR_BAS(BAS), .ADR_MSK(MSK), .CNT_W(8)) dut_c (
        .clk(clk), .rst(rst), .sub_vld(sub_vld), .sub_rdy(rdy_c), .sub_wen(sub_wen), .sub_adr(sub_adr),
        .sub_byt(sub_byt), .sub_wdt(sub_wdt), .sub_rdt(rdt_c), .sub_err(err_c), .sub_rsp(rsp_c),
        .man_vld(mvld_c), .man_rdy(man_rdy), .man_wen(mwen_c), .man_adr(madr_c), .man_byt(mbyt_c),
        .man_wdt(mwdt_c), .man_rdt(man_rdt), .man_err(man_err), .mis_cnt(cnt_c), .mis_clr(mis_clr));

    typedef struct {
        logic        vld;
        logic        wen;
        logic [31:0] adr;
        logic [3:0]  rdy;
        logic [3:0]  err;
        logic [3:0]  exp_man_vld;
        logic        exp_sub_rdy;
        logic        exp_rsp_a;
        logic [31:0] exp_rdt_a;
        logic        exp_err_a;
        logic        exp_rsp_c;
        logic [31:0] exp_rdt_c;
        logic        exp_err_c;
        logic [7:0]  exp_cnt_a;
    } vec_t;

    vec_t vecs [12];

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic applyStimulus(input logic vld, input logic wen, input logic [31:0] adr,
                                 input logic [3:0] rdy, input logic [3:0] err, input logic clr);
        @(negedge clk);
        sub_vld = vld;
        sub_wen = wen;
        sub_adr = adr;
        sub_wdt = adr ^ 32'h5A5A_A5A5;
        sub_byt = 4'hF;
        man_rdy = rdy;
        man_err = err;
        mis_clr = clr;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        man_rdt = RDT;
        //                 vld   wen   adr            rdy   err   mvld  srdy  rspA  rdtA           errA  rspC  rdtC           errC  cntA
        vecs[0]  = '{1'b1, 1'b0, 32'h0020_0044, 4'hF, 4'h0, 4'h4, 1'b1, 1'b0, 32'h0,          1'b0, 1'b1, 32'hCAFE_F00D, 1'b0, 8'd0};
        vecs[1]  = '{1'b1, 1'b0, 32'h0000_0010, 4'hF, 4'h0, 4'h1, 1'b1, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b1, 32'h1111_0000, 1'b0, 8'd0};
        vecs[2]  = '{1'b1, 1'b0, 32'h0020_0000, 4'hF, 4'h0, 4'h2, 1'b1, 1'b1, 32'h1111_0000, 1'b0, 1'b1, 32'h2222_1111, 1'b0, 8'd0};
        vecs[3]  = '{1'b1, 1'b0, 32'h0030_0008, 4'hF, 4'h0, 4'h8, 1'b1, 1'b1, 32'h2222_1111, 1'b0, 1'b1, 32'h4444_3333, 1'b0, 8'd0};
        vecs[4]  = '{1'b1, 1'b1, 32'h4000_0000, 4'hF, 4'h0, 4'h0, 1'b1, 1'b1, 32'h4444_3333, 1'b0, 1'b1, 32'h0,          1'b1, 8'd0};
        vecs[5]  = '{1'b0, 1'b0, 32'h001F_FFFF, 4'hF, 4'h0, 4'h0, 1'b1, 1'b1, 32'h0,          1'b1, 1'b0, 32'h0,          1'b0, 8'd1};
        vecs[6]  = '{1'b1, 1'b0, 32'h0020_003F, 4'hF, 4'h2, 4'h2, 1'b1, 1'b0, 32'h0,          1'b0, 1'b1, 32'h2222_1111, 1'b1, 8'd1};
        vecs[7]  = '{1'b1, 1'b0, 32'h003F_FFFF, 4'hF, 4'h2, 4'h8, 1'b1, 1'b1, 32'h2222_1111, 1'b1, 1'b1, 32'h4444_3333, 1'b0, 8'd1};
        vecs[8]  = '{1'b1, 1'b0, 32'h0040_0000, 4'hF, 4'h0, 4'h0, 1'b1, 1'b1, 32'h4444_3333, 1'b0, 1'b1, 32'h0,          1'b1, 8'd1};
        vecs[9]  = '{1'b1, 1'b0, 32'h0020_0080, 4'hF, 4'h0, 4'h0, 1'b1, 1'b1, 32'h0,          1'b1, 1'b1, 32'h0,          1'b1, 8'd2};
        vecs[10] = '{1'b1, 1'b0, 32'h001F_FFFF, 4'hE, 4'h0, 4'h1, 1'b0, 1'b1, 32'h0,          1'b1, 1'b0, 32'h0,          1'b0, 8'd3};
        vecs[11] = '{1'b0, 1'b0, 32'h0000_0000, 4'hF, 4'h0, 4'h0, 1'b1, 1'b0, 32'h0,          1'b0, 1'b0, 32'h0,          1'b0, 8'd3};

        // Reset: registered outputs cleared, request routing still combinational.
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 32'h0000_0010, 4'hF, 4'h0, 1'b0);
        checkOutput("rst_man_vld", 32'(mvld_a), 32'h1);
        checkOutput("rst_sub_rdy", 32'(rdy_a), 32'h1);
        checkOutput("rst_rsp_a", 32'(rsp_a), 32'h0);
        checkOutput("rst_rdt_a", rdt_a, 32'h0);
        checkOutput("rst_err_a", 32'(err_a), 32'h0);
        checkOutput("rst_rsp_b", 32'(rsp_b), 32'h0);
        checkOutput("rst_cnt_a", 32'(cnt_a), 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 4'hF, 4'h0, 1'b0);
        rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].vld, vecs[i].wen, vecs[i].adr, vecs[i].rdy, vecs[i].err, 1'b0);
            checkOutput($sformatf("v%0d_man_vld", i), 32'(mvld_a), 32'(vecs[i].exp_man_vld));
            checkOutput($sformatf("v%0d_sub_rdy", i), 32'(rdy_a), 32'(vecs[i].exp_sub_rdy));
            checkOutput($sformatf("v%0d_man_adr", i), madr_a, vecs[i].adr);
            checkOutput($sformatf("v%0d_man_wen", i), 32'(mwen_a), 32'(vecs[i].wen));
            checkOutput($sformatf("v%0d_rsp_a", i), 32'(rsp_a), 32'(vecs[i].exp_rsp_a));
            checkOutput($sformatf("v%0d_rdt_a", i), rdt_a, vecs[i].exp_rdt_a);
            checkOutput($sformatf("v%0d_err_a", i), 32'(err_a), 32'(vecs[i].exp_err_a));
            checkOutput($sformatf("v%0d_rsp_c", i), 32'(rsp_c), 32'(vecs[i].exp_rsp_c));
            checkOutput($sformatf("v%0d_rdt_c", i), rdt_c, vecs[i].exp_rdt_c);
            checkOutput($sformatf("v%0d_err_c", i), 32'(err_c), 32'(vecs[i].exp_err_c));
            checkOutput($sformatf("v%0d_cnt_a", i), 32'(cnt_a), 32'(vecs[i].exp_cnt_a));
        end

        // Stall on port 1 for three cycles, then accept; response one cycle later.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h0020_0000, 4'hD, 4'h0, 1'b0);
            checkOutput($sformatf("stall%0d_sub_rdy", i), 32'(rdy_a), 32'h0);
            checkOutput($sformatf("stall%0d_man_vld", i), 32'(mvld_a), 32'h2);
            checkOutput($sformatf("stall%0d_rsp_a", i), 32'(rsp_a), 32'h0);
        end
        applyStimulus(1'b1, 1'b0, 32'h0020_0000, 4'hF, 4'h0, 1'b0);
        checkOutput("stall_go_sub_rdy", 32'(rdy_a), 32'h1);
        checkOutput("stall_go_rsp_a", 32'(rsp_a), 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 4'hF, 4'h0, 1'b0);
        checkOutput("stall_done_rsp_a", 32'(rsp_a), 32'h1);
        checkOutput("stall_done_rdt_a", rdt_a, 32'h2222_1111);
        checkOutput("stall_done_err_a", 32'(err_a), 32'h0);

        // Miss counter: clear, five misses, then clear together with a miss.
        applyStimulus(1'b0, 1'b0, 32'h0, 4'hF, 4'h0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b1, 32'h4000_0000, 4'hF, 4'h0, 1'b0);
            if (i == 0) begin
                checkOutput("clr_cnt_a", 32'(cnt_a), 32'h0);
                checkOutput("clr_cnt_b", 32'(cnt_b), 32'h0);
            end
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 4'hF, 4'h0, 1'b0);
        checkOutput("sat_cnt_b", 32'(cnt_b), 32'h3);
        checkOutput("five_cnt_a", 32'(cnt_a), 32'h5);
        applyStimulus(1'b1, 1'b1, 32'h4000_0000, 4'hF, 4'h0, 1'b1);
        checkOutput("pre_clr_cnt_b", 32'(cnt_b), 32'h3);
        applyStimulus(1'b0, 1'b0, 32'h0, 4'hF, 4'h0, 1'b0);
        checkOutput("clr_wins_cnt_a", 32'(cnt_a), 32'h0);
        checkOutput("clr_wins_cnt_b", 32'(cnt_b), 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 4'hF, 4'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 4'hF, 4'h0, 1'b0);

        // DLY=2 latency, then reset while a miss response is in flight.
        applyStimulus(1'b1, 1'b0, 32'h0020_0044, 4'hF, 4'h0, 1'b0);
        checkOutput("d2_idle_rsp_b", 32'(rsp_b), 32'h0);
        applyStimulus(1'b1, 1'b1, 32'h4000_0000, 4'hF, 4'h0, 1'b0);
        checkOutput("d2_early_rsp_b", 32'(rsp_b), 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 4'hF, 4'h0, 1'b0);
        checkOutput("d2_rsp_b", 32'(rsp_b), 32'h1);
        checkOutput("d2_rdt_b", rdt_b, 32'hCAFE_F00D);
        checkOutput("d2_err_b", 32'(err_b), 32'h0);
        checkOutput("d2_cnt_b", 32'(cnt_b), 32'h1);
        applyStimulus(1'b0, 1'b0, 32'h0, 4'hF, 4'h0, 1'b0);
        rst = 1'b0;
        #1;
        checkOutput("arst_rsp_b", 32'(rsp_b), 32'h0);
        checkOutput("arst_err_b", 32'(err_b), 32'h0);
        checkOutput("arst_cnt_b", 32'(cnt_b), 32'h0);
        checkOutput("arst_cnt_a", 32'(cnt_a), 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 4'hF, 4'h0, 1'b0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 4'hF, 4'h0, 1'b0);
            checkOutput($sformatf("post_rst%0d_rsp_b", i), 32'(rsp_b), 32'h0);
            checkOutput($sformatf("post_rst%0d_rsp_a", i), 32'(rsp_a), 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
